// File: rtl/life_pkg.sv
// Shared types and array geometry for the life array controller slice.
package life_pkg;

  localparam int ROWS      = 16;
  localparam int WIDTH     = 16;
  localparam int ROW_IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    DUMP_SEL,
    DUMP_OUT
  } ctrl_state_t;

endpackage

// File: rtl/life_step_timer.sv
// Period down-counter: counts while tick is high, pulses expire at zero and reloads itself.
module life_step_timer #(
  parameter int PERIOD = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic reload,
  output logic expire
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count;

  assign expire = tick && (count == '0);

  // A held tick (tick=0) freezes the count so a paused run resumes where it left off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= CW'(PERIOD - 1);
    end else if (reload || expire) begin
      count <= CW'(PERIOD - 1);
    end else if (tick) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/life_array_ctrl.sv
// Initiator-side controller for the life array: row load, generation stepping
// and row-by-row scan-out with change tracking.
module life_array_ctrl #(
  parameter int ROWS        = 16,
  parameter int WIDTH       = 16,
  parameter int STEP_PERIOD = 1024,
  parameter int AUTO_DUMP   = 1,
  parameter int GEN_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_start,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic                          run,
  input  logic                          single_step,
  input  logic                          dump_req,
  output logic [WIDTH-1:0]              vali,
  output logic [life_pkg::ROW_IDX_W-1:0] vali_selector,
  output logic                          write_enb,
  output logic                          step,
  output logic [life_pkg::ROW_IDX_W-1:0] valo_selector,
  input  logic [WIDTH-1:0]              valo,
  input  logic [WIDTH-1:0]              valo_prev,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [life_pkg::ROW_IDX_W-1:0] out_row,
  output logic                          out_changed,
  input  logic                          out_ready,
  output logic                          load_done,
  output logic                          dump_done,
  output logic                          stable,
  output logic [GEN_W-1:0]              gen_count
);

  import life_pkg::*;

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

  ctrl_state_t          state;
  logic [ROW_IDX_W-1:0] row;
  logic                 any_changed;
  logic                 row_diff;
  logic                 timer_tick;
  logic                 timer_reload;
  logic                 timer_expire;

  assign row_diff = |(valo ^ valo_prev);

  // Without auto-dump the STEP cycle counts too, so step spacing equals the period exactly.
  assign timer_tick   = run && ((state == IDLE) || ((AUTO_DUMP == 0) && (state == STEP)));
  assign timer_reload = (state == LOAD) && in_valid && in_ready && (row == LAST_ROW);

  life_step_timer #(
    .PERIOD (STEP_PERIOD)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .tick   (timer_tick),
    .reload (timer_reload),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      row           <= '0;
      any_changed   <= 1'b0;
      in_ready      <= 1'b0;
      vali          <= '0;
      vali_selector <= '0;
      write_enb     <= 1'b0;
      step          <= 1'b0;
      valo_selector <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_row       <= '0;
      out_changed   <= 1'b0;
      load_done     <= 1'b0;
      dump_done     <= 1'b0;
      stable        <= 1'b0;
      gen_count     <= '0;
    end else begin
      write_enb <= 1'b0;
      step      <= 1'b0;
      load_done <= 1'b0;
      dump_done <= 1'b0;

      case (state)
        IDLE: begin
          if (load_start) begin
            state     <= LOAD;
            row       <= '0;
            gen_count <= '0;
            in_ready  <= 1'b1;
          end else if (dump_req) begin
            state         <= DUMP_SEL;
            row           <= '0;
            valo_selector <= '0;
            any_changed   <= 1'b0;
          end else if (single_step || timer_expire) begin
            state     <= STEP;
            step      <= 1'b1;
            gen_count <= gen_count + 1'b1;
          end
        end

        LOAD: begin
          if (in_valid && in_ready) begin
            vali          <= in_data;
            vali_selector <= row;
            write_enb     <= 1'b1;
            if (row == LAST_ROW) begin
              in_ready  <= 1'b0;
              load_done <= 1'b1;
              state     <= IDLE;
            end else begin
              row <= row + 1'b1;
            end
          end
        end

        STEP: begin
          if (AUTO_DUMP != 0) begin
            state         <= DUMP_SEL;
            row           <= '0;
            valo_selector <= '0;
            any_changed   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        DUMP_SEL: begin
          out_data    <= valo;
          out_changed <= row_diff;
          out_row     <= row;
          out_valid   <= 1'b1;
          any_changed <= any_changed | row_diff;
          state       <= DUMP_OUT;
        end

        DUMP_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row == LAST_ROW) begin
              dump_done <= 1'b1;
              stable    <= ~any_changed;
              state     <= IDLE;
            end else begin
              row           <= row + 1'b1;
              valo_selector <= row + 1'b1;
              state         <= DUMP_SEL;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_array_ctrl.sv
// Directed bench for life_array_ctrl with a behavioural 16x16 life array behind the row ports.
module tb_life_array_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start, in_valid, run, single_step, dump_req, out_ready;
  logic [15:0] in_data;
  logic        in_ready, write_enb, step, out_valid, out_changed;
  logic        load_done, dump_done, stable;
  logic [15:0] vali, valo, valo_prev, out_data, gen_count;
  logic [3:0]  vali_selector, valo_selector, out_row;

  logic        run_p;
  logic        p_in_ready, p_write_enb, p_step, p_out_valid, p_out_changed;
  logic        p_load_done, p_dump_done, p_stable;
  logic [15:0] p_vali, p_out_data, p_gen_count;
  logic [3:0]  p_vali_selector, p_valo_selector, p_out_row;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_array_ctrl #(
    .ROWS(16), .WIDTH(16), .STEP_PERIOD(8), .AUTO_DUMP(1), .GEN_W(16)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .run(run), .single_step(single_step),
    .dump_req(dump_req), .vali(vali), .vali_selector(vali_selector),
    .write_enb(write_enb), .step(step), .valo_selector(valo_selector),
    .valo(valo), .valo_prev(valo_prev), .out_valid(out_valid),
    .out_data(out_data), .out_row(out_row), .out_changed(out_changed),
    .out_ready(out_ready), .load_done(load_done), .dump_done(dump_done),
    .stable(stable), .gen_count(gen_count)
  );

  // Second instance exercises the free-running step timer without auto-dump.
  life_array_ctrl #(
    .ROWS(16), .WIDTH(16), .STEP_PERIOD(8), .AUTO_DUMP(0), .GEN_W(16)
  ) dut_p (
    .clk(clk), .reset(reset), .load_start(1'b0), .in_valid(1'b0),
    .in_data(16'h0000), .in_ready(p_in_ready), .run(run_p), .single_step(1'b0),
    .dump_req(1'b0), .vali(p_vali), .vali_selector(p_vali_selector),
    .write_enb(p_write_enb), .step(p_step), .valo_selector(p_valo_selector),
    .valo(16'h0000), .valo_prev(16'h0000), .out_valid(p_out_valid),
    .out_data(p_out_data), .out_row(p_out_row), .out_changed(p_out_changed),
    .out_ready(1'b1), .load_done(p_load_done), .dump_done(p_dump_done),
    .stable(p_stable), .gen_count(p_gen_count)
  );

  logic [15:0] cur_rows  [16] = '{default: 16'h0000};
  logic [15:0] prev_rows [16] = '{default: 16'h0000};
  logic [15:0] stim_rows [16];

  assign valo      = cur_rows[valo_selector];
  assign valo_prev = prev_rows[valo_selector];

  function automatic logic [15:0] next_row(input int r);
    logic [15:0] res;
    int n, rr, cc;
    res = 16'h0000;
    for (int c = 0; c < 16; c++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          rr = r + dr;
          cc = c + dc;
          if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16)
            n += int'(cur_rows[rr][cc]);
        end
      end
      res[c] = (n == 3) || (cur_rows[r][c] && n == 2);
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (step) begin
      for (int r = 0; r < 16; r++) begin
        prev_rows[r] <= cur_rows[r];
        cur_rows[r]  <= next_row(r);
      end
    end else if (write_enb) begin
      cur_rows[vali_selector]  <= vali;
      prev_rows[vali_selector] <= vali;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_count = 0;
  int          ld_count = 0;
  int          dd_count = 0;
  int          st_count = 0;
  int          sc_count = 0;
  logic [3:0]  wr_sel  [64];
  logic [15:0] wr_data [64];
  logic [15:0] sc_data [64];
  logic [3:0]  sc_row  [64];
  logic        sc_chg  [64];

  always @(negedge clk) begin
    if (write_enb) begin
      if (wr_count < 64) begin
        wr_sel[wr_count]  <= vali_selector;
        wr_data[wr_count] <= vali;
      end
      wr_count <= wr_count + 1;
    end
    if (out_valid && out_ready) begin
      if (sc_count < 64) begin
        sc_data[sc_count] <= out_data;
        sc_row[sc_count]  <= out_row;
        sc_chg[sc_count]  <= out_changed;
      end
      sc_count <= sc_count + 1;
    end
    if (load_done) ld_count <= ld_count + 1;
    if (dump_done) dd_count <= dd_count + 1;
    if (step)      st_count <= st_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit gapped);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = stim_rows[i];
      tick();
      if (gapped) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        tick();
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_dump(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!ok) begin
        tick();
        if (dump_done) ok = 1'b1;
      end
    end
    checkOutput("dump_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_p_step(output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ok) begin
        tick();
        if (p_step) begin
          ok = 1'b1;
          t  = cyc;
        end
      end
    end
    checkOutput("p_step_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  w0, s0, st0, d0, ld0;
    int  t0, t1, t2, t3;
    bit  ok, bad_a, bad_b, hold_bad, found;
    logic [20:0] held;

    load_start = 0; in_valid = 0; in_data = 0; run = 0; run_p = 0;
    single_step = 0; dump_req = 0; out_ready = 1;
    for (int i = 0; i < 16; i++) stim_rows[i] = 16'h0000;

    repeat (3) tick();
    checkOutput("rst_ctrl", 32'({write_enb, in_ready, out_valid, step, load_done, dump_done, stable}), 32'd0);
    checkOutput("rst_gen", 32'(gen_count), 32'd0);
    checkOutput("rst_sel", 32'({vali_selector, valo_selector, out_row}), 32'd0);
    checkOutput("rst_data", {vali, out_data}, 32'd0);
    reset = 1'b1;
    tick();

    // Reset arriving in the middle of a load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checkOutput("ml_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h1000 + 16'(i);
      tick();
    end
    checkOutput("ml_write4", 32'({write_enb, vali_selector, vali}), 32'({1'b1, 4'd4, 16'h1004}));
    reset = 1'b0;
    #1;
    checkOutput("ml_rst_ctrl", 32'({write_enb, in_ready, vali_selector, vali}), 32'd0);
    w0 = wr_count;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("ml_no_write", 32'(wr_count - w0), 32'd0);
    checkOutput("ml_idle_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();

    // Walking-one load with a bubble between beats.
    for (int i = 0; i < 16; i++) stim_rows[i] = 16'h0001 << i;
    w0 = wr_count; ld0 = ld_count;
    applyStimulus(1'b1);
    checkOutput("ld_writes", 32'(wr_count - w0), 32'd16);
    checkOutput("ld_first_sel", 32'(wr_sel[w0]), 32'd0);
    bad_a = 0; bad_b = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_sel[w0 + i] != 4'(i)) bad_a = 1;
      if (wr_data[w0 + i] != (16'h0001 << i)) bad_b = 1;
    end
    checkOutput("ld_sel_order", 32'(bad_a), 32'd0);
    checkOutput("ld_data", 32'(bad_b), 32'd0);
    checkOutput("ld_done_once", 32'(ld_count - ld0), 32'd1);
    checkOutput("ld_gen", 32'(gen_count), 32'd0);
    checkOutput("ld_ready_off", 32'(in_ready), 32'd0);

    // Blinker: single step followed by automatic scan-out.
    for (int i = 0; i < 16; i++) stim_rows[i] = 16'h0000;
    stim_rows[7] = 16'h0100; stim_rows[8] = 16'h0100; stim_rows[9] = 16'h0100;
    applyStimulus(1'b0);
    s0 = sc_count; st0 = st_count; d0 = dd_count;
    single_step = 1'b1;
    tick();
    single_step = 1'b0;
    checkOutput("bl_step_hi", 32'(step), 32'd1);
    checkOutput("bl_gen", 32'(gen_count), 32'd1);
    tick();
    checkOutput("bl_step_lo", 32'(step), 32'd0);
    wait_dump(ok);
    checkOutput("bl_stable", 32'(stable), 32'd0);
    tick();
    checkOutput("bl_rows", 32'(sc_count - s0), 32'd16);
    checkOutput("bl_step_once", 32'(st_count - st0), 32'd1);
    checkOutput("bl_done_once", 32'(dd_count - d0), 32'd1);
    checkOutput("bl_row7", 32'({sc_chg[s0 + 7], sc_data[s0 + 7]}), 32'({1'b1, 16'h0000}));
    checkOutput("bl_row8", 32'({sc_chg[s0 + 8], sc_data[s0 + 8]}), 32'({1'b1, 16'h0380}));
    checkOutput("bl_row9", 32'({sc_chg[s0 + 9], sc_data[s0 + 9]}), 32'({1'b1, 16'h0000}));
    bad_a = 0; bad_b = 0;
    for (int i = 0; i < 16; i++) begin
      if (sc_row[s0 + i] != 4'(i)) bad_a = 1;
      if ((i < 7 || i > 9) && (sc_chg[s0 + i] || sc_data[s0 + i] != 16'h0000)) bad_b = 1;
    end
    checkOutput("bl_row_order", 32'(bad_a), 32'd0);
    checkOutput("bl_quiet_rows", 32'(bad_b), 32'd0);
    checkOutput("bl_gen_after", 32'(gen_count), 32'd1);

    // Block still life: dump only, with a long back-pressure stall on row 3.
    for (int i = 0; i < 16; i++) stim_rows[i] = 16'h0000;
    stim_rows[4] = 16'h0018; stim_rows[5] = 16'h0018;
    applyStimulus(1'b0);
    s0 = sc_count; st0 = st_count; d0 = dd_count; w0 = wr_count;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        tick();
        if (out_valid && out_row == 4'd3) found = 1;
      end
    end
    checkOutput("hd_reach_row3", 32'(found), 32'd1);
    out_ready = 1'b0;
    held = {out_data, out_row, out_changed};
    hold_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) load_start = 1'b1;
      if (k == 4) single_step = 1'b1;
      if (k == 6) dump_req = 1'b1;
      tick();
      load_start = 1'b0; single_step = 1'b0; dump_req = 1'b0;
      if (!out_valid || {out_data, out_row, out_changed} != held) hold_bad = 1;
    end
    checkOutput("hd_held", 32'(hold_bad), 32'd0);
    checkOutput("hd_row", 32'(out_row), 32'd3);
    checkOutput("hd_no_load", 32'({in_ready, write_enb, step}), 32'd0);
    out_ready = 1'b1;
    wait_dump(ok);
    checkOutput("bk_stable", 32'(stable), 32'd1);
    tick();
    checkOutput("bk_rows", 32'(sc_count - s0), 32'd16);
    checkOutput("bk_row4", 32'({sc_chg[s0 + 4], sc_data[s0 + 4]}), 32'({1'b0, 16'h0018}));
    checkOutput("bk_row5", 32'({sc_chg[s0 + 5], sc_data[s0 + 5]}), 32'({1'b0, 16'h0018}));
    bad_a = 0;
    for (int i = 0; i < 16; i++) if (sc_chg[s0 + i]) bad_a = 1;
    checkOutput("bk_no_change", 32'(bad_a), 32'd0);
    checkOutput("bk_no_step", 32'(st_count - st0), 32'd0);
    checkOutput("bk_no_write", 32'(wr_count - w0), 32'd0);
    checkOutput("bk_done_once", 32'(dd_count - d0), 32'd1);
    checkOutput("bk_gen", 32'(gen_count), 32'd0);

    // Periodic stepping on the non-dumping instance, then a 3-cycle pause of run.
    run_p = 1'b1;
    wait_p_step(t0);
    wait_p_step(t1);
    checkOutput("p_gap1", 32'(t1 - t0), 32'd8);
    wait_p_step(t2);
    checkOutput("p_gap2", 32'(t2 - t1), 32'd8);
    repeat (3) tick();
    run_p = 1'b0;
    repeat (3) tick();
    run_p = 1'b1;
    wait_p_step(t3);
    checkOutput("p_gap_paused", 32'(t3 - t2), 32'd11);
    checkOutput("p_gen", 32'(p_gen_count), 32'd4);
    checkOutput("p_quiet_ctrl", 32'(|{p_in_ready, p_write_enb, p_out_valid, p_load_done, p_dump_done, p_stable, p_out_changed}), 32'd0);
    checkOutput("p_quiet_data", 32'(|{p_vali, p_vali_selector, p_valo_selector, p_out_data, p_out_row}), 32'd0);
    tick();
    checkOutput("p_step_one_cycle", 32'(p_step), 32'd0);
    run_p = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
